// File: rtl/set_bit_index_iter_pkg.sv
// set_bit_index_iter_pkg: shared state encoding and scan-direction constants for the set-bit iterator
package set_bit_index_iter_pkg;
    typedef enum logic {IDLE, ITERATE} state_t;
    localparam logic DIR_BACKWARD = 1'b0;
    localparam logic DIR_FORWARD  = 1'b1;
endpackage

// File: rtl/find_first_one_index_bidir.sv
// find_first_one_index_bidir: combinational find-first-one in either scan direction, with a one-hot of the hit
module find_first_one_index_bidir
    import set_bit_index_iter_pkg::*;
#(
    parameter int VECTOR_LENGTH    = 64,
    parameter int MAX_OUTPUT_WIDTH = 16
) (
    input  logic [VECTOR_LENGTH-1:0]    vector,
    input  logic                        direction,
    output logic [MAX_OUTPUT_WIDTH-1:0] index,
    output logic                        found,
    output logic [VECTOR_LENGTH-1:0]    onehot
);
    // Later loop iterations overwrite earlier ones, so the loop order picks the winning end
    always_comb begin
        index  = '0;
        found  = 1'b0;
        onehot = '0;
        if (direction == DIR_FORWARD) begin
            for (int i = VECTOR_LENGTH - 1; i >= 0; i--) begin
                if (vector[i]) begin
                    index  = i[MAX_OUTPUT_WIDTH-1:0];
                    found  = 1'b1;
                    onehot = '0;
                    onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < VECTOR_LENGTH; i++) begin
                if (vector[i]) begin
                    index  = i[MAX_OUTPUT_WIDTH-1:0];
                    found  = 1'b1;
                    onehot = '0;
                    onehot[i] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/set_bit_index_iterator.sv
// set_bit_index_iterator: enumerates set-bit indices of an accepted vector, one per beat; SET_BIT_ITER_COUNT_EN adds ones_count_out
module set_bit_index_iterator
    import set_bit_index_iter_pkg::*;
#(
    parameter int VECTOR_LENGTH    = 64,
    parameter int MAX_OUTPUT_WIDTH = 16
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic [VECTOR_LENGTH-1:0]    vector_in,
    input  logic                        direction_in,
    input  logic                        vector_valid_in,
    output logic                        vector_ready_out,
    output logic [MAX_OUTPUT_WIDTH-1:0] first_one_index_out,
    output logic                        one_is_found_out,
    output logic                        index_last_out,
    output logic                        index_valid_out,
`ifdef SET_BIT_ITER_COUNT_EN
    output logic [MAX_OUTPUT_WIDTH-1:0] ones_count_out,
`endif
    input  logic                        index_ready_in
);
    localparam logic [VECTOR_LENGTH-1:0] ONE = VECTOR_LENGTH'(1);

    state_t                        state, next_state;
    logic [VECTOR_LENGTH-1:0]      pending_reg;
    logic                          dir_reg;
    logic [MAX_OUTPUT_WIDTH-1:0]   ffo_index;
    logic                          ffo_found;
    logic [VECTOR_LENGTH-1:0]      ffo_onehot;
    logic                          accept, beat;

    find_first_one_index_bidir #(
        .VECTOR_LENGTH(VECTOR_LENGTH),
        .MAX_OUTPUT_WIDTH(MAX_OUTPUT_WIDTH)
    ) u_ffo (
        .vector(pending_reg),
        .direction(dir_reg),
        .index(ffo_index),
        .found(ffo_found),
        .onehot(ffo_onehot)
    );

    assign accept = vector_valid_in && vector_ready_out;
    assign beat   = index_valid_out && index_ready_in;

    // Handshake outputs and next state; index outputs are forced to zero outside ITERATE
    always_comb begin
        vector_ready_out    = state == IDLE;
        index_valid_out     = state == ITERATE;
        first_one_index_out = index_valid_out ? ffo_index : '0;
        one_is_found_out    = index_valid_out && ffo_found;
        index_last_out      = index_valid_out && ((pending_reg & (pending_reg - ONE)) == '0);
        next_state          = state;
        if (accept)
            next_state = ITERATE;
        else if (beat && index_last_out)
            next_state = IDLE;
    end

    // State, captured vector and direction; each transferred beat clears its reported bit
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state       <= IDLE;
            pending_reg <= '0;
            dir_reg     <= DIR_BACKWARD;
        end else begin
            state <= next_state;
            if (accept) begin
                pending_reg <= vector_in;
                dir_reg     <= direction_in;
            end else if (beat) begin
                pending_reg <= pending_reg & ~ffo_onehot;
            end
        end
    end

`ifdef SET_BIT_ITER_COUNT_EN
    logic [MAX_OUTPUT_WIDTH-1:0] popcount;

    // Population count of the incoming vector
    always_comb begin
        popcount = '0;
        for (int i = 0; i < VECTOR_LENGTH; i++)
            popcount = popcount + MAX_OUTPUT_WIDTH'(vector_in[i]);
    end

    // Count is latched at accept and held until the next accept
    always_ff @(posedge clk_in) begin
        if (reset_in)
            ones_count_out <= '0;
        else if (accept)
            ones_count_out <= popcount;
    end
`endif
endmodule
